// File: rtl/ball_field.sv
// ball_field: N bouncing balls plus one player disc, advanced once per frame by a
// one-object-per-clock update FSM; exact squared-distance contact test.
// Pixel colour is produced through a 2-stage pipeline (|dx|,|dy| then rgb).
module ball_field #(
  parameter int N_BALLS  = 5,
  parameter int COORD_W  = 12,
  parameter int BALL_R   = 10,
  parameter int PLAYER_R = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2*N_BALLS-1:0]   seed,
  input  logic                   frame_tick,
  input  logic                   pause,
  input  logic [2:0]             speed,
  input  logic                   up,
  input  logic                   down,
  input  logic                   left,
  input  logic                   right,
  input  logic [COORD_W-1:0]     pix_x,
  input  logic [COORD_W-1:0]     pix_y,
  input  logic                   pix_valid,
  output logic [7:0]             rgb,
  output logic                   rgb_valid,
  output logic                   gameover,
  output logic                   busy,
  output logic [15:0]            frames,
  output logic                   overrun
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PLAYER  = 3'd1;
  localparam logic [2:0] S_BALL    = 3'd2;
  localparam logic [2:0] S_COLLIDE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int IW = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;
  localparam int SW = COORD_W + 1;
  localparam int QW = 2 * COORD_W + 1;

  typedef logic signed [SW-1:0] sc_t;

  // Signed bounds: one extra bit so a negative step result never wraps.
  localparam sc_t BX_LO = sc_t'(BALL_R);
  localparam sc_t BX_HI = sc_t'(SCREEN_W - 1 - BALL_R);
  localparam sc_t BY_LO = sc_t'(BALL_R);
  localparam sc_t BY_HI = sc_t'(SCREEN_H - 1 - BALL_R);

  localparam logic [COORD_W-1:0] PX_LO = COORD_W'(PLAYER_R);
  localparam logic [COORD_W-1:0] PX_HI = COORD_W'(SCREEN_W - 1 - PLAYER_R);
  localparam logic [COORD_W-1:0] PY_LO = COORD_W'(PLAYER_R);
  localparam logic [COORD_W-1:0] PY_HI = COORD_W'(SCREEN_H - 1 - PLAYER_R);

  localparam logic [QW-1:0] HIT_D2 = QW'((BALL_R + PLAYER_R) * (BALL_R + PLAYER_R));
  localparam logic [QW-1:0] BR2    = QW'(BALL_R * BALL_R);
  localparam logic [QW-1:0] PR2    = QW'(PLAYER_R * PLAYER_R);

  localparam logic [IW-1:0] LAST = IW'(N_BALLS - 1);

  function automatic logic [COORD_W-1:0] absdiff(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Full-width squares: nothing is truncated.
  function automatic logic [QW-1:0] dist2(input logic [COORD_W-1:0] dx,
                                          input logic [COORD_W-1:0] dy);
    return QW'(dx) * QW'(dx) + QW'(dy) * QW'(dy);
  endfunction

  logic [2:0]         state;
  logic [IW-1:0]      idx;
  logic [2:0]         spd;
  logic [COORD_W-1:0] player_x, player_y;
  logic [COORD_W-1:0] ball_x [N_BALLS];
  logic [COORD_W-1:0] ball_y [N_BALLS];
  logic [1:0]         ball_dir [N_BALLS];

  logic [COORD_W-1:0] npx, npy;
  sc_t                step, cur_x, cur_y, nx, ny;
  logic [COORD_W-1:0] nbx, nby;
  logic [1:0]         ndir;
  logic               hit;

  assign busy = (state != S_IDLE);

  // Player step candidate: one direction by priority, dropped if it would leave the box.
  always_comb begin
    npx = player_x;
    npy = player_y;
    if (up) begin
      if (player_y > PY_LO) npy = player_y - 1'b1;
    end else if (down) begin
      if (player_y < PY_HI) npy = player_y + 1'b1;
    end else if (left) begin
      if (player_x > PX_LO) npx = player_x - 1'b1;
    end else if (right) begin
      if (player_x < PX_HI) npx = player_x + 1'b1;
    end
  end

  // Ball idx step with per-axis clamp-and-reflect; also the contact test for ball idx.
  always_comb begin
    step  = sc_t'({{(SW-3){1'b0}}, spd});
    cur_x = sc_t'({1'b0, ball_x[idx]});
    cur_y = sc_t'({1'b0, ball_y[idx]});
    nx    = ball_dir[idx][1] ? (cur_x + step) : (cur_x - step);
    ny    = ball_dir[idx][0] ? (cur_y + step) : (cur_y - step);
    ndir  = ball_dir[idx];
    nbx   = nx[COORD_W-1:0];
    nby   = ny[COORD_W-1:0];
    if (nx > BX_HI) begin
      nbx = BX_HI[COORD_W-1:0];
      ndir[1] = ~ndir[1];
    end else if (nx < BX_LO) begin
      nbx = BX_LO[COORD_W-1:0];
      ndir[1] = ~ndir[1];
    end
    if (ny > BY_HI) begin
      nby = BY_HI[COORD_W-1:0];
      ndir[0] = ~ndir[0];
    end else if (ny < BY_LO) begin
      nby = BY_LO[COORD_W-1:0];
      ndir[0] = ~ndir[0];
    end
    hit = dist2(absdiff(ball_x[idx], player_x), absdiff(ball_y[idx], player_y)) <= HIT_D2;
  end

  // World update FSM; start reloads the round, a tick runs PLAYER -> BALL -> COLLIDE -> DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      spd      <= '0;
      gameover <= 1'b0;
      frames   <= '0;
      overrun  <= 1'b0;
      player_x <= COORD_W'(SCREEN_W / 2);
      player_y <= COORD_W'(SCREEN_H / 2);
      for (int i = 0; i < N_BALLS; i++) begin
        ball_x[i]   <= COORD_W'(SCREEN_W * (i + 1) / (N_BALLS + 1));
        ball_y[i]   <= (i % 2 == 0) ? COORD_W'(BALL_R + 1) : COORD_W'(SCREEN_H - 1 - BALL_R);
        ball_dir[i] <= 2'(i);
      end
    end else begin
      if (state != S_IDLE && frame_tick) overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            gameover <= 1'b0;
            frames   <= '0;
            overrun  <= 1'b0;
            player_x <= COORD_W'(SCREEN_W / 2);
            player_y <= COORD_W'(SCREEN_H / 2);
            for (int i = 0; i < N_BALLS; i++) begin
              ball_x[i]   <= COORD_W'(SCREEN_W * (i + 1) / (N_BALLS + 1));
              ball_y[i]   <= (i % 2 == 0) ? COORD_W'(BALL_R + 1) : COORD_W'(SCREEN_H - 1 - BALL_R);
              ball_dir[i] <= seed[2*i +: 2];
            end
          end else if (frame_tick && !pause && !gameover) begin
            spd   <= speed;
            state <= S_PLAYER;
          end
        end
        S_PLAYER: begin
          player_x <= npx;
          player_y <= npy;
          idx      <= '0;
          state    <= S_BALL;
        end
        S_BALL: begin
          ball_x[idx]   <= nbx;
          ball_y[idx]   <= nby;
          ball_dir[idx] <= ndir;
          if (idx == LAST) begin
            idx   <= '0;
            state <= S_COLLIDE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_COLLIDE: begin
          if (hit) gameover <= 1'b1;
          if (idx == LAST) begin
            idx   <= '0;
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (!gameover && frames != 16'hFFFF) frames <= frames + 16'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic               r1_vld, r1_off;
  logic [COORD_W-1:0] r1_pdx, r1_pdy;
  logic [COORD_W-1:0] r1_bdx [N_BALLS];
  logic [COORD_W-1:0] r1_bdy [N_BALLS];
  logic               p_in, b_in;
  logic [7:0]         col;

  // Render stage 1: absolute offsets from the pixel to every object.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_vld <= 1'b0;
      r1_off <= 1'b0;
      r1_pdx <= '0;
      r1_pdy <= '0;
      for (int i = 0; i < N_BALLS; i++) begin
        r1_bdx[i] <= '0;
        r1_bdy[i] <= '0;
      end
    end else begin
      r1_vld <= pix_valid;
      r1_off <= (pix_x >= COORD_W'(SCREEN_W)) || (pix_y >= COORD_W'(SCREEN_H));
      r1_pdx <= absdiff(pix_x, player_x);
      r1_pdy <= absdiff(pix_y, player_y);
      for (int i = 0; i < N_BALLS; i++) begin
        r1_bdx[i] <= absdiff(pix_x, ball_x[i]);
        r1_bdy[i] <= absdiff(pix_y, ball_y[i]);
      end
    end
  end

  // Disc tests and colour priority: off-screen, player, balls, background.
  always_comb begin
    p_in = dist2(r1_pdx, r1_pdy) <= PR2;
    b_in = 1'b0;
    for (int i = 0; i < N_BALLS; i++) begin
      if (dist2(r1_bdx[i], r1_bdy[i]) <= BR2) b_in = 1'b1;
    end
    if (r1_off)    col = 8'h00;
    else if (p_in) col = gameover ? 8'hE0 : 8'hFF;
    else if (b_in) col = 8'hFC;
    else           col = 8'h48;
  end

  // Render stage 2: registered colour and qualifier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb       <= 8'h00;
      rgb_valid <= 1'b0;
    end else begin
      rgb       <= col;
      rgb_valid <= r1_vld;
    end
  end

endmodule

// File: doc/ball_field.md
# ball_field

Parametrised successor to the single-screen dodgeball engine. It owns N bouncing balls and one player disc, and advances them once per video frame through a sequential update FSM that handles one object per clock. It detects player–ball contact with exact squared-distance arithmetic and renders each pixel through a 2-stage pipeline. It sits between the VGA timing generator (pixel coordinates, frame tick) and the DAC output register.

## Interface
- N_BALLS, 5, number of balls (1..16)
- COORD_W, 12, coordinate width
- BALL_R, 10, ball radius (px)
- PLAYER_R, 10, player radius (px)
- SCREEN_W, 640, visible width
- SCREEN_H, 480, visible height
- clk  in  1  pixel/system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  level; (re)load a new round from seed
- seed  in  2*N_BALLS  initial direction bits, 2 per ball
- frame_tick  in  1  1-cycle pulse at start of vertical blank
- pause  in  1  freeze world updates
- speed  in  3  ball step per frame (px/axis); 0 = frozen balls
- up, down, left, right  in  1 each  player controls
- pix_x, pix_y  in  COORD_W  current pixel
- pix_valid  in  1  pixel qualifier
- rgb  out  8  pixel colour
- rgb_valid  out  1  pix_valid delayed by 2
- gameover  out  1  sticky collision flag
- busy  out  1  FSM not in IDLE
- frames  out  16  frames survived, saturating
- overrun  out  1  sticky: frame_tick arrived while busy

## Operation
- Reset values: player at (SCREEN_W/2, SCREEN_H/2); ball i at x = SCREEN_W*(i+1)/(N_BALLS+1), y = BALL_R+1 (even i) or SCREEN_H-1-BALL_R (odd i), dir = i[1:0]; gameover=0, frames=0, overrun=0, busy=0, rgb=0, rgb_valid=0.
- Dir encoding: bit1 = +x, bit0 = +y.
- FSM states: IDLE, PLAYER, BALL, COLLIDE, DONE.
- IDLE, start=1: reload reset positions with dir_i = seed[2i+1:2i]; clear gameover, frames, overrun. Stay in IDLE. start has priority over frame_tick.
- IDLE, frame_tick=1, pause=0, gameover=0: latch speed, go to PLAYER. Otherwise the tick is ignored.
- PLAYER, 1 cycle: move 1 px, priority up>down>left>right. The move happens only if the result stays inside [PLAYER_R, SCREEN_W-1-PLAYER_R] × [PLAYER_R, SCREEN_H-1-PLAYER_R].
- BALL, N_BALLS cycles, index i=0..N-1: step each axis by the latched speed in the dir direction. If the step would leave [BALL_R, SCREEN_W-1-BALL_R] (resp. the H bound), clamp to the bound and flip that dir bit. Each axis is handled independently, so a corner flips both bits.
- COLLIDE, N_BALLS cycles: the contact test is dx²+dy² ≤ (BALL_R+PLAYER_R)², using the updated positions. Any hit sets gameover.
- DONE, 1 cycle: frames += 1, saturating at 0xFFFF, unless gameover was set this frame. Then return to IDLE.
- frame_tick in any non-IDLE state sets overrun and is dropped.
- Arithmetic: |dx|,|dy| are unsigned COORD_W-bit values; squares and sums are 2*COORD_W+1 bits with no truncation. Signed intermediate for bounds is COORD_W+1 bits, so x-speed never wraps.
- Render priority:
  - pix_x ≥ SCREEN_W or pix_y ≥ SCREEN_H → 0x00.
  - else player → 0xFF (0xE0 when gameover).
  - else any ball → 0xFC.
  - else background 0x48.
- Disc test is dx²+dy² ≤ R².

## Timing
- A world update takes 2*N_BALLS+2 cycles after the frame_tick edge. busy is high for exactly those cycles.
- Render latency is 2 cycles:
  - stage 1 registers |dx|,|dy| for all objects;
  - stage 2 registers rgb.
- rgb_valid = pix_valid delayed 2 cycles.
- Positions change only during the update, which occurs in blanking; the render path samples current registers.
- Asynchronous rst mid-update aborts immediately to IDLE with reset values.
- gameover stays set until start or rst.

## Test plan
- Reset, pix (320,240), pix_valid=1 → rgb=0xFF two cycles later, rgb_valid=1. pix (700,10) → rgb=0x00.
- start with seed=0x3FF (all +x,+y), speed=2, 10 frame_ticks → ball0 at (x0+20, 31), frames=10, busy high 12 cycles per tick.
- Ball positioned at x=SCREEN_W-1-BALL_R-1 with +x dir, speed=3 → x=629, dir bit1 cleared. Next frame x=626.
- Player held up for 300 frames → player_y stops at 10. Up+left together → only y moves.
- Place ball at distance exactly 20 from player → gameover=1 after COLLIDE; frames not incremented. At distance 21 → no gameover.
- frame_tick pulsed again 3 cycles after first → overrun=1, single update. rst asserted during BALL → all outputs at reset values the same cycle.
